// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit registers with byte-strobe
// writes. Independent write (AW+W->B) and read (AR->R) FSMs, each allowing
// one outstanding transaction. All outputs are driven straight from flops.
module axi_lite_slave_regfile #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_DATA } rstate_e;

  // Word index lies in ADDR[ADDR_W-1:2]; byte offset is ignored.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({2'b00, a[ADDR_W-1:2]} < ADDR_W'(NUM_REGS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  // Register file
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  // Write path state
  wstate_e           wstate_q, wstate_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;

  // Read path state
  rstate_e     rstate_q, rstate_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;
  assign ar_hs = ARVALID & arready_q;

  logic unused_bits;
  assign unused_bits = ^{AWPROT, ARPROT, awaddr_q[1:0], ARADDR[1:0]};

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  // Write FSM: collect AW and W in any order, commit one edge after both are held
  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    regs_d    = regs_q;
    unique case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awaddr_d  = AWADDR;
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        // Ready rises on the first edge after reset and drops on its handshake
        awready_d = !(aw_done_q || aw_hs);
        wready_d  = !(w_done_q || w_hs);
        if (aw_done_q && w_done_q) begin
          if (in_range(awaddr_q)) begin
            for (int unsigned b = 0; b < 4; b++) begin
              if (wstrb_q[b]) regs_d[word_idx(awaddr_q)][8*b +: 8] = wdata_q[8*b +: 8];
            end
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
          bvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = W_RESP;
        end
      end
      W_RESP: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (BREADY) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read FSM: capture data on the AR handshake edge, hold until R handshake
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          if (in_range(ARADDR)) begin
            rdata_d = regs_q[word_idx(ARADDR)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        arready_d = 1'b0;
        if (RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Register file storage
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write path flops
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Read path flops
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed bench for axi_lite_slave_regfile. Inputs driven and outputs
// sampled on the falling clock edge.
module tb_axi_lite_slave_regfile;

  logic        ACLK;
  logic        ARESETn;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  int n_assert = 0;
  int n_fail   = 0;

  axi_lite_slave_regfile #(.ADDR_W(32), .NUM_REGS(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected end before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // AW and W presented in the same cycle; returns at the negedge after commit
  task automatic wr_req(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input string tag);
    chk({tag, ".awready_pre"}, AWREADY, 1);
    chk({tag, ".wready_pre"}, WREADY, 1);
    AWVALID = 1'b1; AWADDR = addr;
    WVALID  = 1'b1; WDATA = data; WSTRB = strb;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk({tag, ".awready_hs"}, AWREADY, 0);
    chk({tag, ".wready_hs"}, WREADY, 0);
    chk({tag, ".bvalid_hs"}, BVALID, 0);
    @(negedge ACLK);
  endtask

  task automatic wr_resp(input logic [1:0] exp_r, input int hold, input string tag);
    chk({tag, ".bvalid"}, BVALID, 1);
    chk({tag, ".bresp"}, BRESP, exp_r);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      chk({tag, ".hold_bvalid"}, BVALID, 1);
      chk({tag, ".hold_bresp"}, BRESP, exp_r);
      chk({tag, ".hold_awready"}, AWREADY, 0);
      chk({tag, ".hold_wready"}, WREADY, 0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk({tag, ".bvalid_done"}, BVALID, 0);
    chk({tag, ".awready_done"}, AWREADY, 1);
    chk({tag, ".wready_done"}, WREADY, 1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d,
                    input logic [1:0] exp_r, input int hold, input string tag);
    chk({tag, ".arready_pre"}, ARREADY, 1);
    ARVALID = 1'b1; ARADDR = addr; RREADY = 1'b0;
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk({tag, ".rvalid"}, RVALID, 1);
    chk({tag, ".rdata"}, RDATA, exp_d);
    chk({tag, ".rresp"}, RRESP, exp_r);
    chk({tag, ".arready_hs"}, ARREADY, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      chk({tag, ".hold_rvalid"}, RVALID, 1);
      chk({tag, ".hold_rdata"}, RDATA, exp_d);
      chk({tag, ".hold_rresp"}, RRESP, exp_r);
      chk({tag, ".hold_arready"}, ARREADY, 0);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    chk({tag, ".rvalid_done"}, RVALID, 0);
    chk({tag, ".arready_done"}, ARREADY, 1);
  endtask

  initial begin
    ARESETn = 1'b0;
    AWVALID = 1'b0; AWADDR = '0; AWPROT = 3'b010;
    WVALID = 1'b0; WDATA = '0; WSTRB = '0;
    BREADY = 1'b0;
    ARVALID = 1'b0; ARADDR = '0; ARPROT = 3'b001;
    RREADY = 1'b0;

    // Reset state
    repeat (3) @(negedge ACLK);
    chk("rst.awready", AWREADY, 0);
    chk("rst.wready", WREADY, 0);
    chk("rst.arready", ARREADY, 0);
    chk("rst.bvalid", BVALID, 0);
    chk("rst.bresp", BRESP, 0);
    chk("rst.rvalid", RVALID, 0);
    chk("rst.rdata", RDATA, 0);
    chk("rst.rresp", RRESP, 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rel.awready", AWREADY, 1);
    chk("rel.wready", WREADY, 1);
    chk("rel.arready", ARREADY, 1);

    // Full write, AW and W together, then read back
    wr_req(32'h04, 32'hDEADBEEF, 4'hF, "t1w");
    wr_resp(2'b00, 0, "t1w");
    rd(32'h04, 32'hDEADBEEF, 2'b00, 0, "t1r");

    // W two cycles ahead of AW, partial strobe 0101
    WVALID = 1'b1; WDATA = 32'h11223344; WSTRB = 4'b0101;
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("t2.wready", WREADY, 0);
    chk("t2.awready", AWREADY, 1);
    chk("t2.bvalid_a", BVALID, 0);
    @(negedge ACLK);
    chk("t2.bvalid_b", BVALID, 0);
    AWVALID = 1'b1; AWADDR = 32'h04;
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("t2.awready_hs", AWREADY, 0);
    chk("t2.bvalid_c", BVALID, 0);
    @(negedge ACLK);
    wr_resp(2'b00, 0, "t2w");
    rd(32'h04, 32'hDE22BE44, 2'b00, 0, "t2r");

    // Out-of-range index 16 and zero strobe leave registers untouched
    wr_req(32'h40, 32'hCAFEF00D, 4'hF, "t3w");
    wr_resp(2'b10, 0, "t3w");
    rd(32'h40, 32'h0, 2'b10, 0, "t3r_oor");
    rd(32'h00, 32'h0, 2'b00, 0, "t3r_reg0");
    rd(32'h04, 32'hDE22BE44, 2'b00, 0, "t3r_reg1");
    wr_req(32'h05, 32'hFFFFFFFF, 4'h0, "t3z");
    wr_resp(2'b00, 0, "t3z");
    rd(32'h04, 32'hDE22BE44, 2'b00, 0, "t3z_r");

    // Back-pressure on B and R for 5 cycles
    wr_req(32'h0C, 32'h0BADCAFE, 4'hF, "t4w");
    wr_resp(2'b00, 5, "t4w");
    rd(32'h0F, 32'h0BADCAFE, 2'b00, 5, "t4r");

    // Write commit and read capture on the same edge
    wr_req(32'h08, 32'h12345678, 4'hF, "t5pre");
    wr_resp(2'b00, 0, "t5pre");
    AWVALID = 1'b1; AWADDR = 32'h08;
    WVALID = 1'b1; WDATA = 32'h5; WSTRB = 4'hF;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t5.arready", ARREADY, 1);
    ARVALID = 1'b1; ARADDR = 32'h08;
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("t5.bvalid", BVALID, 1);
    chk("t5.rvalid", RVALID, 1);
    chk("t5.rdata_old", RDATA, 32'h12345678);
    chk("t5.rresp", RRESP, 0);
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    chk("t5.bvalid_done", BVALID, 0);
    chk("t5.rvalid_done", RVALID, 0);
    rd(32'h08, 32'h5, 2'b00, 0, "t5r_new");

    // Asynchronous reset while a write response is pending
    wr_req(32'h10, 32'hA5A5A5A5, 4'hF, "t6w");
    chk("t6.bvalid", BVALID, 1);
    #2 ARESETn = 1'b0;
    #1;
    chk("t6.bvalid_async", BVALID, 0);
    chk("t6.awready_async", AWREADY, 0);
    chk("t6.wready_async", WREADY, 0);
    chk("t6.arready_async", ARREADY, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("t6.awready_rel", AWREADY, 1);
    chk("t6.wready_rel", WREADY, 1);
    for (int r = 0; r < 16; r++) begin
      rd(32'(r * 4), 32'h0, 2'b00, 0, "t6r");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
